// File: rtl/hamming_512b_decoder_pkg.sv
// Shared types, code geometry and position mapping for the 512-bit SECDED code.
// Used by the encoder, the decoder and any scrubber.
package defines;

  localparam int HAMMING_512B_PARITY_BITS = 10;
  localparam int HAMMING_512B_CODE_BITS   = 523;
  localparam int HAMMING_512B_DATA_BITS   = 512;

  typedef logic [HAMMING_512B_CODE_BITS-1:0]   hamming_512b_t;
  typedef logic [HAMMING_512B_PARITY_BITS-1:0] hamming_syndrome_t;
  typedef logic [HAMMING_512B_DATA_BITS-1:0]   cache_line_data_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_CORRECTED,
    ERR_UNCORRECTABLE
  } err_class_e;

  // Hamming position (1-based) to data-bit index; -1 for parity positions.
  // Data index = pos - 1 - (number of powers of two below pos).
  function automatic int hamming_pos_to_data_idx(input int pos);
    int lg;
    lg = 0;
    if (pos < 1 || (pos & (pos - 1)) == 0) return -1;
    for (int k = 0; k < HAMMING_512B_PARITY_BITS; k++) begin
      if ((pos >> k) != 0) lg = k;
    end
    return pos - 2 - lg;
  endfunction

endpackage

// File: rtl/hamming_512b_decoder_if.sv
// Read-path bus of the SECDED decoder: codeword in, corrected line, flags and counters out.
interface hamming_512b_decoder_if
  import defines::*;
#(
  parameter int COUNT_WIDTH = 16
);

  logic                   in_valid;
  hamming_512b_t          coded_word;
  logic                   out_valid;
  cache_line_data_t       decoded_word;
  logic                   err_corrected;
  logic                   err_uncorrectable;
  hamming_syndrome_t      err_syndrome;
  logic                   count_clear;
  logic [COUNT_WIDTH-1:0] corrected_count;
  logic [COUNT_WIDTH-1:0] uncorrectable_count;

  modport master (
    output in_valid, coded_word, count_clear,
    input  out_valid, decoded_word, err_corrected, err_uncorrectable, err_syndrome,
           corrected_count, uncorrectable_count
  );

  modport slave (
    input  in_valid, coded_word, count_clear,
    output out_valid, decoded_word, err_corrected, err_uncorrectable, err_syndrome,
           corrected_count, uncorrectable_count
  );

endinterface

// File: rtl/hamming_512b_syndrome.sv
// Combinational syndrome and overall-parity generator for hamming_512b_t codewords.
module hamming_512b_syndrome
  import defines::*;
(
  input  hamming_512b_t     coded_word_i,
  output hamming_syndrome_t syndrome_o,
  output logic              parity_o
);

  // NOTE: combinational accumulators use blocking '=' and are cleared first so no latch is inferred.
  always_comb begin
    syndrome_o = '0;
    for (int i = 0; i < HAMMING_512B_CODE_BITS - 1; i++) begin
      if (coded_word_i[10'(i)]) syndrome_o ^= hamming_syndrome_t'(i + 1);
    end
  end

  assign parity_o = ^coded_word_i;

endmodule

// File: rtl/hamming_512b_decoder.sv
// Two-stage SECDED decoder for 512-bit cache lines with saturating error counters.
// Stage 1 registers word/syndrome/parity; stage 2 registers corrected data and flags.
module hamming_512b_decoder
  import defines::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input logic                   clk,
  input logic                   reset,
  hamming_512b_decoder_if.slave bus
);

  localparam hamming_syndrome_t LAST_POS = hamming_syndrome_t'(HAMMING_512B_CODE_BITS - 1);

  typedef logic [COUNT_WIDTH-1:0] count_t;

  hamming_syndrome_t s1_syn_d, s1_syn_q;
  logic              s1_par_d, s1_par_q;
  logic              s1_valid_q;
  hamming_512b_t     s1_word_q;

  err_class_e        err_class;
  hamming_512b_t     fixed_word;
  cache_line_data_t  data_d, data_q;
  logic              out_valid_q, corr_q, unc_q;
  hamming_syndrome_t syn_q;
  count_t            corr_cnt_d, corr_cnt_q, unc_cnt_d, unc_cnt_q;

  hamming_512b_syndrome u_syndrome (
    .coded_word_i (bus.coded_word),
    .syndrome_o   (s1_syn_d),
    .parity_o     (s1_par_d)
  );

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else begin
      s1_valid_q <= bus.in_valid;
      s1_word_q  <= bus.coded_word;
      s1_syn_q   <= s1_syn_d;
      s1_par_q   <= s1_par_d;
    end
  end

  always_comb begin
    err_class = ERR_NONE;
    if (s1_syn_q == '0) begin
      if (s1_par_q) err_class = ERR_CORRECTED;
    end else if (s1_par_q && s1_syn_q <= LAST_POS) begin
      err_class = ERR_CORRECTED;
    end else begin
      err_class = ERR_UNCORRECTABLE;
    end
  end

  // A zero syndrome matches no position, so overall-parity errors leave the word untouched.
  always_comb begin
    fixed_word = s1_word_q;
    for (int i = 0; i < HAMMING_512B_CODE_BITS - 1; i++) begin
      fixed_word[10'(i)] = s1_word_q[10'(i)] ^
                           ((err_class == ERR_CORRECTED) && (s1_syn_q == hamming_syndrome_t'(i + 1)));
    end
  end

  always_comb begin
    data_d = '0;
    for (int pos = 1; pos < HAMMING_512B_CODE_BITS; pos++) begin
      if (hamming_pos_to_data_idx(pos) >= 0) begin
        data_d[9'(hamming_pos_to_data_idx(pos))] = fixed_word[10'(pos - 1)];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      corr_q      <= 1'b0;
      unc_q       <= 1'b0;
      data_q      <= '0;
      syn_q       <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      corr_q      <= s1_valid_q && (err_class == ERR_CORRECTED);
      unc_q       <= s1_valid_q && (err_class == ERR_UNCORRECTABLE);
      if (s1_valid_q) begin
        data_q <= data_d;
        syn_q  <= s1_syn_q;
      end
    end
  end

  // Clear has priority over a same-cycle increment; counts hold at all-ones.
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    unc_cnt_d  = unc_cnt_q;
    if (bus.count_clear) begin
      corr_cnt_d = '0;
      unc_cnt_d  = '0;
    end else begin
      if (out_valid_q && corr_q && corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + 1'b1;
      if (out_valid_q && unc_q && unc_cnt_q != '1)   unc_cnt_d  = unc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
    end else begin
      corr_cnt_q <= corr_cnt_d;
      unc_cnt_q  <= unc_cnt_d;
    end
  end

  assign bus.out_valid           = out_valid_q;
  assign bus.decoded_word        = data_q;
  assign bus.err_corrected       = corr_q;
  assign bus.err_uncorrectable   = unc_q;
  assign bus.err_syndrome        = syn_q;
  assign bus.corrected_count     = corr_cnt_q;
  assign bus.uncorrectable_count = unc_cnt_q;

endmodule

// File: tb/tb_hamming_512b_decoder.sv
// Scoreboard bench for hamming_512b_decoder: directed codewords, counter saturation/clear,
// and a random stream with 0/1/2 bit flips, bubbles and a mid-stream reset.
module tb_hamming_512b_decoder;
  import defines::*;

  localparam int CW = 2;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef struct {
    cache_line_data_t  data;
    logic              corr;
    logic              unc;
    hamming_syndrome_t syn;
    int                cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [CW-1:0] m_corr_cnt, m_unc_cnt;
  logic          prev_corr, prev_unc;

  always #5 clk = ~clk;

  hamming_512b_decoder_if #(.COUNT_WIDTH(CW)) bus ();

  hamming_512b_decoder #(.COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic hamming_512b_t encode(input cache_line_data_t d);
    hamming_512b_t     w;
    hamming_syndrome_t s;
    int                k;
    w = '0;
    s = '0;
    k = 0;
    for (int pos = 1; pos <= 522; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        w[10'(pos - 1)] = d[9'(k)];
        k++;
      end
    end
    for (int pos = 1; pos <= 522; pos++) if (w[10'(pos - 1)]) s ^= hamming_syndrome_t'(pos);
    for (int j = 0; j < 10; j++) w[10'((1 << j) - 1)] = s[j];
    w[522] = ^w[521:0];
    return w;
  endfunction

  function automatic cache_line_data_t extract(input hamming_512b_t w);
    cache_line_data_t d;
    int               k;
    d = '0;
    k = 0;
    for (int pos = 1; pos <= 522; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[9'(k)] = w[10'(pos - 1)];
        k++;
      end
    end
    return d;
  endfunction

  function automatic hamming_syndrome_t bitpos(input int b);
    return (b == 522) ? hamming_syndrome_t'(0) : hamming_syndrome_t'(b + 1);
  endfunction

  function automatic exp_t mk(input cache_line_data_t d, input logic c, input logic u,
                              input hamming_syndrome_t s);
    exp_t e;
    e.data = d;
    e.corr = c;
    e.unc  = u;
    e.syn  = s;
    e.cyc  = 0;
    return e;
  endfunction

  task automatic monitor(input logic clr);
    exp_t e;
    if (clr) begin
      m_corr_cnt = '0;
      m_unc_cnt  = '0;
    end else begin
      if (prev_corr && m_corr_cnt != CNT_MAX) m_corr_cnt = m_corr_cnt + 1'b1;
      if (prev_unc && m_unc_cnt != CNT_MAX)   m_unc_cnt  = m_unc_cnt + 1'b1;
    end
    prev_corr = 1'b0;
    prev_unc  = 1'b0;
    check("corrected_count", 512'(bus.corrected_count), 512'(m_corr_cnt));
    check("uncorrectable_count", 512'(bus.uncorrectable_count), 512'(m_unc_cnt));
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 512'(bus.out_valid), 512'(0));
      end else begin
        e = sb.pop_front();
        check("latency", 512'(cyc - e.cyc), 512'(2));
        check("decoded_word", bus.decoded_word, e.data);
        check("err_corrected", 512'(bus.err_corrected), 512'(e.corr));
        check("err_uncorrectable", 512'(bus.err_uncorrectable), 512'(e.unc));
        check("err_syndrome", 512'(bus.err_syndrome), 512'(e.syn));
        prev_corr = e.corr;
        prev_unc  = e.unc;
      end
    end else begin
      check("idle_err_corrected", 512'(bus.err_corrected), 512'(0));
      check("idle_err_uncorrectable", 512'(bus.err_uncorrectable), 512'(0));
    end
  endtask

  task automatic step(input logic v, input hamming_512b_t w, input logic clr, input exp_t e);
    bus.in_valid    = v;
    bus.coded_word  = w;
    bus.count_clear = clr;
    if (v) begin
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
    monitor(clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, mk('0, 1'b0, 1'b0, '0));
  endtask

  task automatic apply_reset();
    reset           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.count_clear = 1'b0;
    #2;
    check("rst_out_valid", 512'(bus.out_valid), 512'(0));
    check("rst_decoded_word", bus.decoded_word, 512'(0));
    check("rst_err_corrected", 512'(bus.err_corrected), 512'(0));
    check("rst_err_uncorrectable", 512'(bus.err_uncorrectable), 512'(0));
    check("rst_err_syndrome", 512'(bus.err_syndrome), 512'(0));
    check("rst_corrected_count", 512'(bus.corrected_count), 512'(0));
    check("rst_uncorrectable_count", 512'(bus.uncorrectable_count), 512'(0));
    sb.delete();
    m_corr_cnt = '0;
    m_unc_cnt  = '0;
    prev_corr  = 1'b0;
    prev_unc   = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(3);
  endtask

  initial begin
    hamming_512b_t    one_w, w;
    cache_line_data_t d;
    int               n, b1, b2;
    logic             v, clr;
    exp_t             e;

    bus.in_valid    = 1'b0;
    bus.coded_word  = '0;
    bus.count_clear = 1'b0;
    #1;
    apply_reset();

    // Directed codewords around the encoding of data 1.
    one_w = {1'b1, 519'b0, 3'b111};
    step(1'b1, '0, 1'b0, mk(512'd0, 1'b0, 1'b0, 10'd0));
    step(1'b1, one_w, 1'b0, mk(512'd1, 1'b0, 1'b0, 10'd0));
    w = one_w; w[2] = 1'b0;
    step(1'b1, w, 1'b0, mk(512'd1, 1'b1, 1'b0, 10'd3));
    w = one_w; w[522] = 1'b0;
    step(1'b1, w, 1'b0, mk(512'd1, 1'b1, 1'b0, 10'd0));
    w = one_w; w[0] = 1'b0;
    step(1'b1, w, 1'b0, mk(512'd1, 1'b1, 1'b0, 10'd1));
    w = one_w; w[1:0] = 2'b00;
    step(1'b1, w, 1'b0, mk(512'd1, 1'b0, 1'b1, 10'd3));
    idle(3);

    // Saturation at 3, then clear colliding with a corrected output.
    step(1'b0, '0, 1'b1, mk('0, 1'b0, 1'b0, '0));
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom();
      b1 = k * 97 + 5;
      w = encode(d);
      w[10'(b1)] = ~w[10'(b1)];
      step(1'b1, w, 1'b0, mk(d, 1'b1, 1'b0, bitpos(b1)));
    end
    step(1'b0, '0, 1'b0, mk('0, 1'b0, 1'b0, '0));
    step(1'b0, '0, 1'b1, mk('0, 1'b0, 1'b0, '0));
    idle(2);

    // Random stream with bubbles, occasional clears and a mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) apply_reset();
      v   = ($urandom_range(3) != 0);
      clr = ($urandom_range(19) == 0);
      for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom();
      w  = encode(d);
      n  = int'($urandom_range(2));
      b1 = int'($urandom_range(522));
      b2 = (b1 + 1 + int'($urandom_range(521))) % 523;
      if (n == 0) begin
        e = mk(d, 1'b0, 1'b0, '0);
      end else if (n == 1) begin
        w[10'(b1)] = ~w[10'(b1)];
        e = mk(d, 1'b1, 1'b0, bitpos(b1));
      end else begin
        w[10'(b1)] = ~w[10'(b1)];
        w[10'(b2)] = ~w[10'(b2)];
        e = mk(extract(w), 1'b0, 1'b1, bitpos(b1) ^ bitpos(b2));
      end
      step(v, w, clr, e);
    end
    idle(4);
    check("scoreboard_drain", 512'(sb.size()), 512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
